// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and op decode helpers for the nibble ALU sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC = 3'd1,
    SUB = 3'd2,
    SBC = 3'd3,
    AND = 3'd4,
    XOR = 3'd5,
    OR  = 3'd6,
    CP  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice control triple {R,S,V}; arithmetic ops all share the adder path.
  function automatic logic [2:0] op_rsv(alu_op_t op);
    case (op)
      XOR:     return 3'b100;
      AND:     return 3'b010;
      OR:      return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_sub(alu_op_t op);
    return (op == SUB) || (op == SBC) || (op == CP);
  endfunction

  function automatic logic is_logic(alu_op_t op);
    return (op == AND) || (op == XOR) || (op == OR);
  endfunction

endpackage

// File: rtl/alu_nibble.sv
// rtl/alu_nibble.sv - combinational 4-bit ALU slice (add / xor / and / or)
module alu_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       R,
  input  logic       S,
  input  logic       V,
  output logic [3:0] sum,
  output logic       cout,
  output logic       vout
);

  logic [4:0] full;
  logic [3:0] low3;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    // low3[3] is the carry into bit 3, needed for signed overflow
    low3 = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    sum  = full[3:0];
    cout = full[4];
    vout = low3[3] ^ full[4];
    case ({R, S, V})
      3'b100: begin sum = a ^ b; cout = 1'b0; vout = 1'b0; end
      3'b010: begin sum = a & b; cout = 1'b0; vout = 1'b0; end
      3'b111: begin sum = a | b; cout = 1'b0; vout = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - nibble-serial ALU sequencer with Z80-style flags
import alu_seq_pkg::*;

module alu_nibble_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cy_in,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             hf,
  output logic             vf,
  output logic             zf,
  output logic             sf
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = $clog2(NIB) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  state_t           state_q, state_d;
  alu_op_t          op_q, op_d, op_in;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d, hc_q, hc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [4:0]       fl_q, fl_d;

  logic             sub_op, logic_op, h_src;
  logic [2:0]       rsv;
  logic [3:0]       a_nib, b_nib, sum;
  logic             cout, vout;
  logic [WIDTH-1:0] full;

  assign op_in = alu_op_t'(op);

  always_comb begin
    sub_op   = is_sub(op_q);
    logic_op = is_logic(op_q);
    rsv      = op_rsv(op_q);
    a_nib    = 4'(a_q >> {k_q, 2'b00});
    b_nib    = sub_op ? ~4'(b_q >> {k_q, 2'b00}) : 4'(b_q >> {k_q, 2'b00});
  end

  alu_nibble u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .R    (rsv[2]),
    .S    (rsv[1]),
    .V    (rsv[0]),
    .sum  (sum),
    .cout (cout),
    .vout (vout)
  );

  // Accumulator is cleared at start, so OR-ing the new nibble in is enough.
  assign full = acc_q | (WIDTH'(sum) << {k_q, 2'b00});

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    carry_d = carry_q;
    hc_d    = hc_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    fl_d    = fl_q;
    h_src   = (k_q == '0) ? cout : hc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_in;
          a_d     = op1;
          b_d     = op2;
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
          case (op_in)
            ADC:     carry_d = cy_in;
            SUB, CP: carry_d = 1'b1;
            SBC:     carry_d = ~cy_in;
            default: carry_d = 1'b0;
          endcase
        end
      end
      RUN: begin
        acc_d   = full;
        carry_d = cout;
        k_d     = k_q + KW'(1);
        if (k_q == '0) hc_d = cout;
        if (k_q == K_LAST) begin
          state_d = DONE;
          fl_d = {logic_op ? 1'b0 : (cout ^ sub_op),
                  logic_op ? (op_q == AND) : (h_src ^ sub_op),
                  logic_op ? ~^full : vout,
                  full == '0,
                  full[WIDTH-1]};
          if (op_q != CP) res_d = full;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= ADD;
      k_q     <= '0;
      carry_q <= 1'b0;
      hc_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      hc_q    <= hc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      fl_q    <= fl_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign {cf, hf, vf, zf, sf} = fl_q;

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Parametrised multi-nibble ALU sequencer. It computes a WIDTH-bit arithmetic or logic operation one 4-bit nibble per clock, least-significant nibble first, through a single 4-bit core slice. Carry is chained between slices in a register. It produces Z80-style flags (C, H, V/P, Z, S) and has a start/ready/done handshake. It sits between the operand latches and the flag/result registers of the execution datapath.

## Interface
- WIDTH, 8, operand/result width; a multiple of 4, range 4..32. NIB = WIDTH/4.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- op  in  3  operation (alu_op_t), sampled with start.
- cy_in  in  1  carry/borrow in for ADC/SBC, sampled with start.
- op1, op2  in  WIDTH  operands, sampled with start.
- ready  out  1  high only in state IDLE.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  registered result.
- cf, hf, vf, zf, sf  out  1 each  registered flags.

## Operation
- FSM states:
  - IDLE: start&ready at an edge latches op, cy_in, op1, op2; clears the accumulator; sets nibble index k=0; goes to RUN.
  - RUN: each edge processes nibble k, shifts its sum into accumulator bits [4k+3:4k], stores the slice carry, and increments k. At the edge with k=NIB-1 it goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Initial carry:
  - ADD and logic ops: 0.
  - ADC: cy_in.
  - SUB/CP: 1.
  - SBC: ~cy_in.
- SUB/SBC/CP feed ~op2 nibble to the slice.
- Slice control (R,S,V):
  - ADD/ADC/SUB/SBC/CP: 000.
  - XOR: 100.
  - AND: 010.
  - OR: 111.
- Flags, loaded at the last RUN edge together with result:
  - cf: slice carry out of the MS nibble for ADD/ADC; inverted for SUB/SBC/CP; 0 for logic ops.
  - hf: carry out of nibble 0, inverted for subtract ops; 1 for AND, 0 for XOR/OR.
  - vf: for arithmetic ops, the slice vout of the MS nibble (carry into bit 3 XOR carry out); for logic ops, even parity of the full result (1 = even number of ones).
  - zf: full WIDTH result == 0.
  - sf: result MSB.
- CP updates flags only; the result output holds its previous value.
- Outputs hold between operations. The result and flag registers change only at the last RUN edge of an accepted operation.
- start outside IDLE (RUN or DONE) is ignored; it is not queued.
- reset, any time including mid-RUN: state IDLE, k=0, carry=0, accumulator=0, result=0, all flags 0, done=0, ready=1.

## Timing
- Start accepted at edge E0.
- Nibble j is computed combinationally during cycle j+1 and registered at E(j+1).
- done=1 in the cycle after E(NIB); result and flags are valid in that same cycle.
- ready=1 again after E(NIB+1).
- Back-to-back throughput: one operation per NIB+2 cycles.
- Slice path is purely combinational: nibble mux, 4-bit slice, carry register. There is no combinational path from inputs to outputs except ready, which is decoded from state.

## Structure
- Package alu_seq_pkg:
  - alu_op_t enum: ADD=0, ADC=1, SUB=2, SBC=3, AND=4, XOR=5, OR=6, CP=7.
  - state_t enum: IDLE, RUN, DONE.
  - Function that maps alu_op_t to the R,S,V triple.
  - Functions for is_sub and is_logic.
- Sub-module alu_nibble: combinational 4-bit slice.
  - Inputs a[3:0], b[3:0], cin, R, S, V.
  - Outputs sum[3:0], cout, vout.
  - R,S,V = 000: a+b+cin; 100: a^b; 010: a&b; 111: a|b.
- Top: FSM, nibble index counter (width clog2(NIB)+1), carry flop, accumulator, output registers, parity/zero reduction.

## Test plan
- WIDTH=8, ADD 0x3A+0xC7 -> result 0x01; cf=1, hf=1, vf=0, zf=0, sf=0. done high exactly in the 3rd cycle after the start edge; ready low for 3 cycles.
- WIDTH=8, SUB 0x80-0x01 -> 0x7F; cf=0, hf=1, vf=1, sf=0. Then SBC 0x00-0x00 with cy_in=1 -> 0xFF; cf=1, hf=1, vf=0, sf=1.
- WIDTH=8, AND 0xF0&0x0F -> 0x00; zf=1, hf=1, cf=0, vf=1. Then XOR 0x96^0xFF -> 0x69; vf=1, hf=0. Then OR 0x01|0x02 -> 0x03; vf=1.
- WIDTH=8, after ADD result 0x01, CP 0x42 vs 0x42 -> zf=1, cf=0, result still 0x01. start pulsed during RUN and DONE -> ignored; exactly one done per accepted start.
- WIDTH=16, ADC 0xFFFF+0x0000 with cy_in=1 -> 0x0000; cf=1, zf=1, hf=1. done in the 5th cycle after start.
- Reset asserted mid-RUN -> immediately ready=1, done=0, result=0, all flags 0. The next start completes normally with a full NIB+1-cycle latency.
